// File: rtl/eth_stats_log_arb_pkg.sv
// Shared types and constants for the Ethernet latency stats log write path.
package eth_stats_log_arb_pkg;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [15:0] seq_num;
    logic [31:0] latency_ns;
  } eth_latency_stats_struct;

  localparam int ETH_LATENCY_STATS_STRUCT_W = $bits(eth_latency_stats_struct);
  localparam int ETH_STATS_DROP_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FROZEN = 2'd2
  } eth_stats_arb_state_e;

  // Index width for a source count; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_stats_log_arb_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_rr_ptr, wrapping.
module eth_stats_log_arb_rr_arbiter
  import eth_stats_log_arb_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  localparam int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_SRC-1:0] o_gnt_oh,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_any
);

  int               w_sum;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_sum     = 0;
    w_cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = int'(i_rr_ptr) + k;
      if (w_sum >= NUM_SRC) w_sum = w_sum - NUM_SRC;
      w_cand = IDX_W'(w_sum);
      if (!o_gnt_any && i_req[w_cand]) begin
        o_gnt_any        = 1'b1;
        o_gnt_oh[w_cand] = 1'b1;
        o_gnt_idx        = w_cand;
      end
    end
  end

endmodule

// File: rtl/eth_stats_log_arb.sv
// Merges per-source record pulses onto the single stats log write port, with
// a freeze handshake for the log reader and per-source drop counters.
module eth_stats_log_arb
  import eth_stats_log_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int LOG_DATA_W = -1,
  parameter  int DROP_CNT_W = ETH_STATS_DROP_CNT_W,
  // Clamp keeps the default elaboration legal; real users override LOG_DATA_W.
  localparam int DW         = (LOG_DATA_W > 0) ? LOG_DATA_W : 1,
  localparam int IDX_W      = idx_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_wr_val,
  input  logic [NUM_SRC*DW-1:0]         src_wr_data,
  output logic                          log_wr_req_val,
  output logic [DW-1:0]                 log_wr_req_data,
  input  logic                          freeze_req,
  output logic                          freeze_ack,
  input  logic                          clr_drop_cnt,
  output logic [NUM_SRC*DROP_CNT_W-1:0] drop_cnt,
  output eth_stats_arb_state_e          o_dbg_state,
  output logic [IDX_W-1:0]              o_dbg_rr_ptr
);

  // src_wr_val and log_wr_req_val are single-cycle qualifiers with no ready:
  // a record is taken in the cycle its valid is high, and the data beside it
  // is meaningful only in that cycle.

  eth_stats_arb_state_e  r_state, w_state_nxt;
  logic [NUM_SRC-1:0]    r_pend_val;
  logic [DW-1:0]         r_pend_data [NUM_SRC];
  logic [IDX_W-1:0]      r_rr_ptr;
  logic                  r_log_val;
  logic [DW-1:0]         r_log_data;
  logic [DROP_CNT_W-1:0] r_drop_cnt  [NUM_SRC];

  logic [NUM_SRC-1:0] w_req, w_gnt_oh, w_load, w_drop;
  logic [IDX_W-1:0]   w_gnt_idx, w_ptr_nxt;
  logic               w_gnt_any, w_grant_en, w_capture_en, w_freeze_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (freeze_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!freeze_req)                          w_state_nxt = ST_RUN;
        else if ((r_pend_val == '0) && !r_log_val) w_state_nxt = ST_FROZEN;
      end
      ST_FROZEN: if (!freeze_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_grant_en   = 1'b0;
    w_capture_en = 1'b0;
    w_freeze_ack = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_grant_en   = 1'b1;
        w_capture_en = 1'b1;
      end
      ST_DRAIN:  w_grant_en   = 1'b1;
      ST_FROZEN: w_freeze_ack = 1'b1;
      default: begin end
    endcase
  end

  assign w_req = r_pend_val & {NUM_SRC{w_grant_en}};

  eth_stats_log_arb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr_arbiter (
    .i_req     (w_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;

  // A slot being granted this cycle can take a new record without loss.
  always_comb begin
    w_load = '0;
    w_drop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_wr_val[i]) begin
        if (w_capture_en && (!r_pend_val[i] || w_gnt_oh[i])) w_load[i] = 1'b1;
        else                                                  w_drop[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_rr_ptr   <= '0;
      r_log_val  <= 1'b0;
      r_log_data <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_drop_cnt[i] <= '0;
    end else begin
      r_log_val  <= w_gnt_any;
      r_log_data <= w_gnt_any ? r_pend_data[w_gnt_idx] : '0;
      if (w_gnt_any) r_rr_ptr <= w_ptr_nxt;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_load[i])        r_pend_val[i] <= 1'b1;
        else if (w_gnt_oh[i]) r_pend_val[i] <= 1'b0;
        // Clear first, then count the same-cycle drop on top of it.
        if (clr_drop_cnt)
          r_drop_cnt[i] <= DROP_CNT_W'(w_drop[i]);
        else if (w_drop[i] && (r_drop_cnt[i] != '1))
          r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_load[i]) r_pend_data[i] <= src_wr_data[i*DW +: DW];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop_cnt
    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = r_drop_cnt[g];
  end

  assign log_wr_req_val  = r_log_val;
  assign log_wr_req_data = r_log_data;
  assign freeze_ack      = w_freeze_ack;
  assign o_dbg_state     = r_state;
  assign o_dbg_rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_eth_stats_log_arb.sv
// Scoreboard bench for eth_stats_log_arb: directed pulses, expected writes
// queued with their expected cycle, and a monitor popping on each log write.
module tb_eth_stats_log_arb;
  import eth_stats_log_arb_pkg::*;

  localparam int NS = 2;
  localparam int DW = 64;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NS-1:0]        src_wr_val;
  logic [NS*DW-1:0]     src_wr_data;
  logic                 log_wr_req_val;
  logic [DW-1:0]        log_wr_req_data;
  logic                 freeze_req;
  logic                 freeze_ack;
  logic                 clr_drop_cnt;
  logic [NS*CW-1:0]     drop_cnt;
  eth_stats_arb_state_e dbg_state;
  logic [0:0]           dbg_rr_ptr;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  logic [95:0] exp_q[$];
  logic [63:0] t3b_exp [11] = '{64'h70, 64'h60, 64'h71, 64'h62, 64'h73, 64'h64,
                                64'h75, 64'h66, 64'h77, 64'h68, 64'h79};

  eth_stats_log_arb #(.NUM_SRC(NS), .LOG_DATA_W(DW), .DROP_CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_wr_val      (src_wr_val),
    .src_wr_data     (src_wr_data),
    .log_wr_req_val  (log_wr_req_val),
    .log_wr_req_data (log_wr_req_data),
    .freeze_req      (freeze_req),
    .freeze_ack      (freeze_ack),
    .clr_drop_cnt    (clr_drop_cnt),
    .drop_cnt        (drop_cnt),
    .o_dbg_state     (dbg_state),
    .o_dbg_rr_ptr    (dbg_rr_ptr)
  );

  // Clock and cycle label: cycle c is the interval after the c-th rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] drop_of(input int i);
    return 64'(drop_cnt[i*CW +: CW]);
  endfunction

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1);
    src_wr_val  = v;
    src_wr_data = {d1, d0};
  endtask

  task automatic push_exp(input int c, input logic [63:0] d);
    logic [31:0] cc;
    cc = c;
    exp_q.push_back({cc, d});
  endtask

  task automatic run_monitor();
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (log_wr_req_val === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, expected no write",
                   log_wr_req_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", log_wr_req_data, e[63:0]);
          check("wr_cycle", 64'(cyc), 64'(e[95:64]));
        end
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_val"},   64'(log_wr_req_val), 64'h0);
    check({tag, "_data"},  log_wr_req_data,     64'h0);
    check({tag, "_ack"},   64'(freeze_ack),     64'h0);
    check({tag, "_drop0"}, drop_of(0),          64'h0);
    check({tag, "_drop1"}, drop_of(1),          64'h0);
    check({tag, "_state"}, 64'(dbg_state),      64'(ST_RUN));
    check({tag, "_ptr"},   64'(dbg_rr_ptr),     64'h0);
  endtask

  initial begin
    int c;
    rst_n        = 1'b0;
    freeze_req   = 1'b0;
    clr_drop_cnt = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    fork
      run_monitor();
    join_none

    // Reset state
    repeat (3) next();
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) next();

    // Single source, uncontended: write two cycles after the pulse
    c = cyc;
    push_exp(c + 2, 64'hA5);
    drive(2'b01, 64'hA5, 64'h0);
    next();
    drive(2'b00, 64'h0, 64'h0);
    repeat (3) next();
    check("t1_ptr", 64'(dbg_rr_ptr), 64'h1);
    check("t1_drop0", drop_of(0), 64'h0);

    c = cyc;
    push_exp(c + 2, 64'hB6);
    drive(2'b10, 64'h0, 64'hB6);
    next();
    drive(2'b00, 64'h0, 64'h0);
    repeat (3) next();
    check("t1b_ptr", 64'(dbg_rr_ptr), 64'h0);

    // Simultaneous arrival from rr_ptr=0
    c = cyc;
    push_exp(c + 2, 64'h11);
    push_exp(c + 3, 64'h22);
    drive(2'b11, 64'h11, 64'h22);
    next();
    drive(2'b00, 64'h0, 64'h0);
    repeat (4) next();
    check("t2_drop0", drop_of(0), 64'h0);
    check("t2_drop1", drop_of(1), 64'h0);

    // Collision: grant/refill keeps source 1 lossless, source 0 loses one
    c = cyc;
    push_exp(c + 2, 64'h40);
    push_exp(c + 3, 64'h51);
    push_exp(c + 4, 64'h41);
    push_exp(c + 5, 64'h52);
    push_exp(c + 6, 64'h43);
    for (int k = 0; k < 4; k++) begin
      drive({(k == 1 || k == 2), 1'b1}, 64'h40 + 64'(k), 64'h50 + 64'(k));
      next();
    end
    drive(2'b00, 64'h0, 64'h0);
    repeat (6) next();
    check("t3a_drop0", drop_of(0), 64'h1);
    check("t3a_drop1", drop_of(1), 64'h0);
    clr_drop_cnt = 1'b1;
    next();
    clr_drop_cnt = 1'b0;
    next();
    check("clr_drop0", drop_of(0), 64'h0);
    check("t3b_ptr_start", 64'(dbg_rr_ptr), 64'h1);

    // Both sources every cycle for 10 cycles
    c = cyc;
    for (int j = 0; j < 11; j++) push_exp(c + 2 + j, t3b_exp[j]);
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 64'h60 + 64'(k), 64'h70 + 64'(k));
      next();
    end
    drive(2'b00, 64'h0, 64'h0);
    repeat (14) next();
    check("t3b_drop0", drop_of(0), 64'h5);
    check("t3b_drop1", drop_of(1), 64'h4);
    check("t3b_ptr_end", 64'(dbg_rr_ptr), 64'h0);

    // Freeze with both entries pending
    clr_drop_cnt = 1'b1;
    next();
    clr_drop_cnt = 1'b0;
    c = cyc;
    push_exp(c + 2, 64'h81);
    push_exp(c + 3, 64'h82);
    drive(2'b11, 64'h81, 64'h82);
    next();
    freeze_req = 1'b1;
    drive(2'b00, 64'h0, 64'h0);
    next();
    check("t4_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
    drive(2'b10, 64'h0, 64'h99);
    next();
    drive(2'b00, 64'h0, 64'h0);
    check("t4_ack_c3", 64'(freeze_ack), 64'h0);
    next();
    check("t4_ack_c4", 64'(freeze_ack), 64'h0);
    next();
    check("t4_ack_c5", 64'(freeze_ack), 64'h1);
    check("t4_state_frozen", 64'(dbg_state), 64'(ST_FROZEN));
    check("t4_drain_drop1", drop_of(1), 64'h1);
    next();
    drive(2'b01, 64'h9A, 64'h0);
    next();
    drive(2'b00, 64'h0, 64'h0);
    next();
    check("t4_frozen_drop0", drop_of(0), 64'h1);
    check("t4_ack_held", 64'(freeze_ack), 64'h1);
    freeze_req = 1'b0;
    next();
    check("t4_ack_fall", 64'(freeze_ack), 64'h0);
    check("t4_state_run", 64'(dbg_state), 64'(ST_RUN));
    c = cyc;
    push_exp(c + 2, 64'hAB);
    drive(2'b01, 64'hAB, 64'h0);
    next();
    drive(2'b00, 64'h0, 64'h0);
    repeat (4) next();

    // Saturation and clear-with-drop, using FROZEN to force drops
    freeze_req = 1'b1;
    repeat (3) next();
    check("t5_ack", 64'(freeze_ack), 64'h1);
    clr_drop_cnt = 1'b1;
    next();
    clr_drop_cnt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(2'b01, 64'(k), 64'h0);
      next();
    end
    drive(2'b00, 64'h0, 64'h0);
    next();
    check("t5_sat_drop0", drop_of(0), 64'hF);
    check("t5_sat_drop1", drop_of(1), 64'h0);
    clr_drop_cnt = 1'b1;
    drive(2'b01, 64'h5A, 64'h0);
    next();
    clr_drop_cnt = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    next();
    check("t5_clr_with_drop", drop_of(0), 64'h1);
    freeze_req = 1'b0;
    repeat (2) next();
    check("t5_ack_off", 64'(freeze_ack), 64'h0);

    // Reset with records pending: nothing written, everything back to zero
    check("t6_ptr_before", 64'(dbg_rr_ptr), 64'h1);
    drive(2'b11, 64'hD1, 64'hD2);
    next();
    drive(2'b00, 64'h0, 64'h0);
    rst_n = 1'b0;
    repeat (2) next();
    check_quiet("t6_reset");
    rst_n = 1'b1;
    repeat (5) next();
    check("t6_no_write", 64'(log_wr_req_val), 64'h0);

    check("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_stats_log_arb.md
# eth_stats_log_arb

Write-side scheduler for the Ethernet latency stats log. It merges fire-and-forget record pulses from up to `NUM_SRC` recorders (e.g. TX and RX latency recorders) onto the single `simple_log` write port, using round-robin arbitration and one pending slot per source. It also provides a freeze handshake, so that the UDP/NoC log reader can dump a quiescent log, and counts records lost to collisions or to freeze.

## Interface
Parameters:
- `NUM_SRC`, 2: number of recorder sources, ≥1.
- `LOG_DATA_W`, -1: width of one log record, must be overridden (e.g. `ETH_LATENCY_STATS_STRUCT_W`).
- `DROP_CNT_W`, 16: width of each per-source drop counter.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `src_wr_val`  in  `NUM_SRC`  per-source record pulse, no backpressure.
- `src_wr_data`  in  `NUM_SRC*LOG_DATA_W`  records; source i occupies bits [i*LOG_DATA_W +: LOG_DATA_W].
- `log_wr_req_val`  out  1  write strobe to the log.
- `log_wr_req_data`  out  `LOG_DATA_W`  record to the log.
- `freeze_req`  in  1  level; reader requests a quiescent log.
- `freeze_ack`  out  1  level; log is quiescent, with no write issued or pending.
- `clr_drop_cnt`  in  1  pulse; clears all drop counters.
- `drop_cnt`  out  `NUM_SRC*DROP_CNT_W`  per-source saturating drop counts.

## Operation
- Each source has one pending register, holding a valid bit and data.
- State machine `RUN`, `DRAIN`, `FROZEN`.
- `RUN`:
  - Capture: `src_wr_val[i]` loads pending[i].
  - Grant: each cycle, grant the first valid pending entry at or after `rr_ptr`, wrapping modulo `NUM_SRC`.
  - The granted entry is cleared, and its data is registered onto `log_wr_req_*`.
  - After a grant, `rr_ptr` = granted+1 (mod `NUM_SRC`). With no grant, `rr_ptr` holds.
- Same-cycle grant and arrival on source i: the pending entry is refilled with the new record. No drop.
- Arrival on source i while pending[i] is valid and not granted this cycle: the record is dropped and drop_cnt[i] increments.
- `RUN`→`DRAIN` when `freeze_req`=1.
- `DRAIN`:
  - Granting continues.
  - All new arrivals are dropped and counted.
  - →`FROZEN` in the cycle after all pending entries are empty and `log_wr_req_val`=0.
- `FROZEN`:
  - `freeze_ack`=1, with no grants and no writes.
  - Arrivals are dropped and counted.
  - →`RUN` when `freeze_req`=0.
- `freeze_req` deasserted while in `DRAIN`: return to `RUN`. Pending entries are retained.
- Drop counters:
  - Saturate at 2^`DROP_CNT_W`-1.
  - `clr_drop_cnt` is applied first, then the same-cycle increment, so the result is 1 if a drop coincides with the clear.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - All outputs are 0: `log_wr_req_val`, `log_wr_req_data`, `freeze_ack` and every `drop_cnt`.
  - All pending valid bits are 0, `rr_ptr`=0, state=`RUN`.
  - Reset mid-operation discards pending records without counting them.
- Latency: `src_wr_val` in cycle N captures the record at edge N. The record is granted in N+1, and `log_wr_req_val`=1 in N+2 when uncontended.
- Throughput: one log write per cycle aggregate.
- Worst-case wait for a held record: `NUM_SRC` grant cycles.
- `log_wr_req_val` is a one-cycle pulse per record. `log_wr_req_data` is valid only while it is high.
- `freeze_ack`:
  - Rises at least one cycle after the final `log_wr_req_val` pulse.
  - Falls at the edge where `FROZEN` sees `freeze_req`=0, i.e. one cycle after deassertion.
  - Never high in `RUN` or `DRAIN`.
- `drop_cnt` is registered: it updates one edge after the dropped arrival.

## Structure
- Shared stats package:
  - state enum `eth_stats_arb_state_e`.
  - default `DROP_CNT_W`.
  - existing `eth_latency_stats_struct` and `ETH_LATENCY_STATS_STRUCT_W`.
- One natural sub-module: `rr_arbiter`, parameterised on `NUM_SRC`. It takes a request vector and `rr_ptr` and returns a one-hot grant plus index, combinationally.
- Pending registers, counters and the FSM live in `eth_stats_log_arb`.

## Test plan
1. Single source, uncontended: `NUM_SRC`=2, `LOG_DATA_W`=64. Pulse `src_wr_val`=2'b01 with data 0xA5 in cycle 10 → `log_wr_req_val`=1 with 0xA5 in cycle 12. No drops.
2. Simultaneous arrival: both sources pulse in cycle 5 (0x11 on source 0, 0x22 on source 1), `rr_ptr`=0 → writes 0x11 in cycle 7 and 0x22 in cycle 8. No drops.
3. Collision: source 1 pulses in cycles 5 and 6 while source 0 pulses continuously from cycle 4.
   - Required response: two writes from source 1, with drop_cnt[1] staying 0 because of the grant/refill rule.
   - Then hold source 0 under contention with both sources pulsing every cycle for 10 cycles → writes alternate 0,1,0,1…, and drop counts match the arrivals not written.
4. Freeze: fill both pending entries, then assert `freeze_req`.
   - Required response: both records are written, then `freeze_ack` rises.
   - A pulse arriving during `FROZEN` → drop_cnt[i]=1 and no write.
   - Deassert `freeze_req` → `freeze_ack` drops next cycle, and a new pulse is written 2 cycles later.
5. Saturation and clear: `DROP_CNT_W`=4 with 20 forced drops → count 15. A `clr_drop_cnt` coincident with a drop → count 1.
6. Reset mid-operation: `rst_n`=0 with records pending → no writes afterwards, all outputs 0, `rr_ptr` back to 0.
